controle_soma_fp: RTL and testbench

- Multi-cycle sequencer for half-precision (1/5/10) floating-point add/subtract.
- Sequences the compare, align, add and normalize stages over a shared 12-bit mantissa register.
- Normalization follows the team's 12-bit mantissa convention: bit11 carry, bit10 hidden, [9:0] fraction.
- Sits between the operand source and the result consumer, with a start/done handshake.

---
 rtl/controle_soma_fp.sv | 229 ++++++++++++++++++++++
 tb/tb_controle_soma_fp.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_soma_fp.sv
// controle_soma_fp: multi-cycle sequencer for half-precision (1/5/10) add/subtract.
// Stages COMPARA -> ALINHA -> SOMA -> NORMALIZA run over a shared 12-bit mantissa
// register (bit11 carry, bit10 hidden, [9:0] fraction). Denormals flush to zero,
// exponent 31 is infinity, shifted-out bits are truncated.
// Optional feature: define FP_FLAGS_EN to add the flag_overflow / flag_zero outputs.
module controle_soma_fp #(
    parameter int unsigned MAX_DESLOC = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inicio,
    input  logic [15:0] operando_A,
    input  logic [15:0] operando_B,
    input  logic        operacao,
    output logic        ocupado,
    output logic        pronto,
    output logic [15:0] resultado
`ifdef FP_FLAGS_EN
    ,
    output logic        flag_overflow,
    output logic        flag_zero
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StCompara,
        StAlinha,
        StSoma,
        StNormaliza,
        StFim
    } estado_e;

    estado_e     estado_q;
    logic        ocupado_q;
    logic        pronto_q;
    logic [15:0] resultado_q;

    // Latched operands; b_q already carries the effective sign (sB ^ operacao).
    logic [15:0] a_q;
    logic [15:0] b_q;

    // Datapath: X is the larger magnitude, mant_x_q doubles as the sum/normalize register.
    logic        sinal_q;
    logic        subtrai_q;
    logic [4:0]  exp_q;
    logic [4:0]  desloc_q;
    logic [11:0] mant_x_q;
    logic [11:0] mant_y_q;

    logic [4:0]  exp_a;
    logic [4:0]  exp_b;
    logic        a_maior;
    logic [4:0]  desloc_d;

    // Result request: raised in the cycle whose edge moves the FSM into FIM.
    logic        fim_req;
    logic [15:0] fim_res;
    logic        fim_ovf;

    assign exp_a    = a_q[14:10];
    assign exp_b    = b_q[14:10];
    assign a_maior  = (a_q[14:0] >= b_q[14:0]);
    assign desloc_d = a_maior ? (exp_a - exp_b) : (exp_b - exp_a);

    // Decide whether this cycle terminates the operation and with which result.
    always_comb begin
        fim_req = 1'b0;
        fim_res = 16'h0000;
        fim_ovf = 1'b0;
        case (estado_q)
            StCompara: begin
                if (exp_a == 5'h1F) begin
                    fim_req = 1'b1;
                    fim_res = {a_q[15], 5'h1F, 10'h000};
                end else if (exp_b == 5'h1F) begin
                    fim_req = 1'b1;
                    fim_res = {b_q[15], 5'h1F, 10'h000};
                end else if (exp_a == 5'h00) begin
                    fim_req = 1'b1;
                    fim_res = (exp_b == 5'h00) ? 16'h0000 : b_q;
                end else if (exp_b == 5'h00) begin
                    fim_req = 1'b1;
                    fim_res = a_q;
                end
            end
            StNormaliza: begin
                if (mant_x_q == 12'h000) begin
                    fim_req = 1'b1;
                end else if (exp_q == 5'h1F) begin
                    // Reached only through a carry shift in a previous cycle.
                    fim_req = 1'b1;
                    fim_res = {sinal_q, 5'h1F, 10'h000};
                    fim_ovf = 1'b1;
                end else if (mant_x_q[11]) begin
                    fim_req = 1'b0;
                end else if (!mant_x_q[10] && (exp_q > 5'd1)) begin
                    fim_req = 1'b0;
                end else if (!mant_x_q[10]) begin
                    // Would underflow below the smallest normal exponent.
                    fim_req = 1'b1;
                end else begin
                    fim_req = 1'b1;
                    fim_res = {sinal_q, exp_q, mant_x_q[9:0]};
                end
            end
            default: ;
        endcase
    end

    // Main sequencer: state, datapath registers and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= StIdle;
            ocupado_q   <= 1'b0;
            pronto_q    <= 1'b0;
            resultado_q <= 16'h0000;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            sinal_q     <= 1'b0;
            subtrai_q   <= 1'b0;
            exp_q       <= 5'd0;
            desloc_q    <= 5'd0;
            mant_x_q    <= 12'h000;
            mant_y_q    <= 12'h000;
        end else begin
            pronto_q <= 1'b0;
            case (estado_q)
                StIdle: begin
                    if (inicio) begin
                        a_q       <= operando_A;
                        b_q       <= {operando_B[15] ^ operacao, operando_B[14:0]};
                        ocupado_q <= 1'b1;
                        estado_q  <= StCompara;
                    end
                end
                StCompara: begin
                    if (fim_req) begin
                        resultado_q <= fim_res;
                        pronto_q    <= 1'b1;
                        estado_q    <= StFim;
                    end else begin
                        if (a_maior) begin
                            mant_x_q <= {2'b01, a_q[9:0]};
                            mant_y_q <= {2'b01, b_q[9:0]};
                            exp_q    <= exp_a;
                            sinal_q  <= a_q[15];
                        end else begin
                            mant_x_q <= {2'b01, b_q[9:0]};
                            mant_y_q <= {2'b01, a_q[9:0]};
                            exp_q    <= exp_b;
                            sinal_q  <= b_q[15];
                        end
                        subtrai_q <= a_q[15] ^ b_q[15];
                        desloc_q  <= desloc_d;
                        estado_q  <= (desloc_d == 5'd0) ? StSoma : StAlinha;
                    end
                end
                StAlinha: begin
                    if ({27'd0, desloc_q} > MAX_DESLOC) begin
                        // Every bit would be shifted out anyway: flush in one cycle.
                        mant_y_q <= 12'h000;
                        desloc_q <= 5'd0;
                        estado_q <= StSoma;
                    end else begin
                        mant_y_q <= mant_y_q >> 1;
                        desloc_q <= desloc_q - 5'd1;
                        if (desloc_q == 5'd1) begin
                            estado_q <= StSoma;
                        end
                    end
                end
                StSoma: begin
                    // The swap guarantees mant_x_q >= mant_y_q, so no borrow out.
                    mant_x_q <= subtrai_q ? (mant_x_q - mant_y_q) : (mant_x_q + mant_y_q);
                    estado_q <= StNormaliza;
                end
                StNormaliza: begin
                    if (fim_req) begin
                        resultado_q <= fim_res;
                        pronto_q    <= 1'b1;
                        estado_q    <= StFim;
                    end else if (mant_x_q[11]) begin
                        mant_x_q <= mant_x_q >> 1;
                        exp_q    <= exp_q + 5'd1;
                    end else begin
                        mant_x_q <= mant_x_q << 1;
                        exp_q    <= exp_q - 5'd1;
                    end
                end
                StFim: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= StIdle;
                end
                default: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= StIdle;
                end
            endcase
        end
    end

    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign resultado = resultado_q;

`ifdef FP_FLAGS_EN
    logic flag_overflow_q;
    logic flag_zero_q;

    // Status flags: cleared on accept, loaded on the same edge as resultado.
    always_ff @(posedge clock) begin
        if (reset) begin
            flag_overflow_q <= 1'b0;
            flag_zero_q     <= 1'b0;
        end else if ((estado_q == StIdle) && inicio) begin
            flag_overflow_q <= 1'b0;
            flag_zero_q     <= 1'b0;
        end else if (fim_req) begin
            flag_overflow_q <= fim_ovf;
            flag_zero_q     <= (fim_res[14:0] == 15'h0000);
        end
    end

    assign flag_overflow = flag_overflow_q;
    assign flag_zero     = flag_zero_q;
`endif

endmodule

// File: tb/tb_controle_soma_fp.sv
// Self-checking bench for controle_soma_fp: directed cases plus randomized operands
// compared against an arithmetic reference model (result, latency, overflow flag).
module tb_controle_soma_fp;

    logic        clock = 1'b0;
    logic        reset;
    logic        inicio;
    logic [15:0] operando_A;
    logic [15:0] operando_B;
    logic        operacao;
    logic        ocupado;
    logic        pronto;
    logic [15:0] resultado;
`ifdef FP_FLAGS_EN
    logic        flag_overflow;
    logic        flag_zero;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    controle_soma_fp #(
        .MAX_DESLOC(11)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .inicio    (inicio),
        .operando_A(operando_A),
        .operando_B(operando_B),
        .operacao  (operacao),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .resultado (resultado)
`ifdef FP_FLAGS_EN
        ,
        .flag_overflow(flag_overflow),
        .flag_zero    (flag_zero)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: value semantics of the operation plus the cycle cost of each rule.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic op,
                                  output logic [15:0] res, output int lat, output bit ovf);
        logic sb, s;
        int ea, eb, ex, ey, fx, fy, mx, my, d, dc, sum, e, n, msb, lz;
        sb  = b[15] ^ op;
        ea  = int'(a[14:10]);
        eb  = int'(b[14:10]);
        ovf = 1'b0;
        lat = 2;
        res = 16'h0000;
        if (ea == 31) begin
            res = {a[15], 5'h1F, 10'h000};
        end else if (eb == 31) begin
            res = {sb, 5'h1F, 10'h000};
        end else if (ea == 0) begin
            res = (eb == 0) ? 16'h0000 : {sb, b[14:0]};
        end else if (eb == 0) begin
            res = a;
        end else begin
            if (a[14:0] >= b[14:0]) begin
                ex = ea; ey = eb; fx = int'(a[9:0]); fy = int'(b[9:0]); s = a[15];
            end else begin
                ex = eb; ey = ea; fx = int'(b[9:0]); fy = int'(a[9:0]); s = sb;
            end
            mx = 1024 + fx;
            my = 1024 + fy;
            d  = ex - ey;
            if (d > 11) begin
                my = 0;
                dc = 1;
            end else begin
                my = my >> d;
                dc = d;
            end
            sum = (a[15] == sb) ? (mx + my) : (mx - my);
            e   = ex;
            n   = 0;
            if (sum == 0) begin
                res = 16'h0000;
            end else if (sum >= 2048) begin
                n = 1;
                e = e + 1;
                if (e == 31) begin
                    res = {s, 5'h1F, 10'h000};
                    ovf = 1'b1;
                end else begin
                    res = {s, 5'(e), 10'((sum >> 1) & 1023)};
                end
            end else begin
                msb = 0;
                for (int i = 0; i < 12; i++) if (((sum >> i) & 1) == 1) msb = i;
                lz = 10 - msb;
                if (e <= lz) begin
                    n   = e - 1;
                    res = 16'h0000;
                end else begin
                    n   = lz;
                    e   = e - lz;
                    res = {s, 5'(e), 10'((sum << lz) & 1023)};
                end
            end
            lat = 4 + dc + n;
        end
    endfunction

    // One operation from IDLE: start, count edges to pronto, check result and return to IDLE.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic op, input logic [15:0] exp_res, input int exp_lat,
                          input bit exp_ovf);
        int lat;
        @(negedge clock);
        operando_A = a;
        operando_B = b;
        operacao   = op;
        inicio     = 1'b1;
        @(posedge clock);
        #1;
        inicio     = 1'b0;
        operando_A = 16'($urandom);
        operando_B = 16'($urandom);
        operacao   = 1'($urandom);
        chk({tag, ":ocupado"}, 32'(ocupado), 32'd1);
`ifdef FP_FLAGS_EN
        chk({tag, ":flags_clr"}, {30'd0, flag_overflow, flag_zero}, 32'd0);
`endif
        lat = 1;
        while (pronto !== 1'b1 && lat < 60) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk({tag, ":lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ":res"}, 32'(resultado), 32'(exp_res));
`ifdef FP_FLAGS_EN
        chk({tag, ":ovf"}, 32'(flag_overflow), 32'(exp_ovf));
        chk({tag, ":zero"}, 32'(flag_zero), 32'(exp_res[14:0] == 15'h0000));
`endif
        @(posedge clock);
        #1;
        chk({tag, ":pulso"}, {30'd0, pronto, ocupado}, 32'd0);
    endtask

    function automatic logic [15:0] rand_op();
        int k;
        logic [4:0] e;
        k = int'($urandom_range(0, 11));
        if (k == 0) e = 5'd0;
        else if (k == 1) e = 5'd31;
        else e = 5'($urandom_range(1, 30));
        return {1'($urandom), e, 10'($urandom)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, b, r;
        logic        op;
        int          l, pulsos;
        bit          v;

        reset      = 1'b1;
        inicio     = 1'b0;
        operando_A = 16'h0000;
        operando_B = 16'h0000;
        operacao   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", {13'd0, ocupado, pronto, 1'b0, resultado}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Directed cases with hand-derived expectations.
        run_op("1p1",      16'h3C00, 16'h3C00, 1'b0, 16'h4000, 5,  1'b0);
        run_op("1m1",      16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4,  1'b0);
        run_op("1p0.5",    16'h3C00, 16'h3800, 1'b0, 16'h3E00, 5,  1'b0);
        run_op("flushY",   16'h3C00, 16'h0400, 1'b0, 16'h3C00, 5,  1'b0);
        run_op("ovf",      16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5,  1'b1);
        run_op("zeroA",    16'h0000, 16'hC200, 1'b0, 16'hC200, 2,  1'b0);
        run_op("cancel",   16'h3C00, 16'h3BFF, 1'b1, 16'h1400, 15, 1'b0);
        run_op("infB_sub", 16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 2,  1'b0);
        run_op("bothzero", 16'h0000, 16'h8000, 1'b0, 16'h0000, 2,  1'b0);

        // inicio held high while busy must not disturb the running operation.
        @(negedge clock);
        operando_A = 16'h3C00;
        operando_B = 16'h3BFF;
        operacao   = 1'b1;
        inicio     = 1'b1;
        @(posedge clock);
        #1;
        operando_A = 16'h7BFF;
        operando_B = 16'h7BFF;
        operacao   = 1'b0;
        l = 1;
        while (pronto !== 1'b1 && l < 60) begin
            inicio = (l < 6);
            @(posedge clock);
            #1;
            l++;
        end
        inicio = 1'b0;
        chk("busy:lat", 32'(l), 32'd15);
        chk("busy:res", 32'(resultado), 32'h1400);
        repeat (4) @(posedge clock);
        #1;
        chk("busy:idle", {15'd0, ocupado, resultado}, 32'h1400);

        // Reset in the middle of alignment discards the operation.
        @(negedge clock);
        operando_A = 16'h3C00;
        operando_B = 16'h2C00;
        operacao   = 1'b0;
        inicio     = 1'b1;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        @(posedge clock);
        #1;
        chk("rst:alinha_busy", 32'(ocupado), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst:state", {13'd0, ocupado, pronto, 1'b0, resultado}, 32'd0);
        @(negedge clock);
        reset  = 1'b0;
        pulsos = 0;
        repeat (30) begin
            @(posedge clock);
            #1;
            if (pronto === 1'b1 || ocupado === 1'b1) pulsos++;
        end
        chk("rst:quiet", 32'(pulsos), 32'd0);

        // Randomized operands against the reference model.
        for (int i = 0; i < 150; i++) begin
            a  = rand_op();
            b  = rand_op();
            op = 1'($urandom);
            if ($urandom_range(0, 2) == 0 && a[14:10] != 5'd0 && a[14:10] != 5'd31) begin
                b[14:10] = a[14:10];
            end
            model(a, b, op, r, l, v);
            run_op($sformatf("rnd%0d_%h_%h_%0d", i, a, b, op), a, b, op, r, l, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
